rr_mux_arb: RTL

- Parametrised, registered N:1 channel multiplexer; the sequential successor to the team's decoder-built 4:1 mux.
- Selects one of NUM_CH valid/ready input channels and registers the chosen word plus its channel index into a single output stage.
- Two selection modes:
  - round-robin arbitration;
  - fixed select, equivalent to the old 4:1 mux with S1,S0 driven by fix_sel.
- Sits between multiple producers and one shared consumer.

---
 rtl/rr_mux_pkg.sv | 22 ++
 rtl/rr_grant.sv | 47 ++++
 rtl/rr_mux_arb.sv | 118 +++++++++++
 3 files changed

// File: rtl/rr_mux_pkg.sv
// Shared types and helpers for the round-robin registered channel mux.
package rr_mux_pkg;

  typedef enum logic {
    EMPTY  = 1'b0,
    LOADED = 1'b1
  } state_e;

  localparam logic MODE_RR  = 1'b0;
  localparam logic MODE_FIX = 1'b1;

  // Width needed to index n items, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'd1 << i) < n) w = i + 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational grant selection: rotating priority from rr_ptr, or a fixed channel index.
module rr_grant
  import rr_mux_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  localparam int unsigned SEL_W = clog2_min1(NUM_CH)
) (
  input  logic [NUM_CH-1:0] in_valid,
  input  logic [SEL_W-1:0]  rr_ptr,
  input  logic              mode,
  input  logic [SEL_W-1:0]  fix_sel,
  output logic              grant_valid,
  output logic [SEL_W-1:0]  grant_idx
);

  localparam int unsigned PadW = 1 << SEL_W;

  // Unused index codes of a non-power-of-2 channel count read as not valid.
  logic [PadW-1:0]  valid_pad;
  logic [SEL_W:0]   pos;
  logic             rr_valid;
  logic [SEL_W-1:0] rr_idx;
  logic             fix_valid;

  assign valid_pad = PadW'(in_valid);

  // Scan from the far end back so the nearest valid channel after rr_ptr wins.
  always_comb begin
    rr_valid = 1'b0;
    rr_idx   = '0;
    pos      = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      pos = {1'b0, rr_ptr} + (SEL_W + 1)'(i);
      if (pos >= (SEL_W + 1)'(NUM_CH)) pos = pos - (SEL_W + 1)'(NUM_CH);
      if (valid_pad[pos[SEL_W-1:0]]) begin
        rr_valid = 1'b1;
        rr_idx   = pos[SEL_W-1:0];
      end
    end
  end

  assign fix_valid = ({1'b0, fix_sel} < (SEL_W + 1)'(NUM_CH)) && valid_pad[fix_sel];

  assign grant_valid = (mode == MODE_FIX) ? fix_valid : rr_valid;
  assign grant_idx   = (mode == MODE_FIX) ? fix_sel : rr_idx;

endmodule

// File: rtl/rr_mux_arb.sv
// Registered N:1 valid/ready channel mux with round-robin or fixed selection.
// Define RRMUX_PARITY_EN to add a registered even-parity output out_par.
module rr_mux_arb
  import rr_mux_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned WIDTH  = 8,
  localparam int unsigned SEL_W = clog2_min1(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        fix_sel,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
`ifdef RRMUX_PARITY_EN
  output logic                    out_par,
`endif
  input  logic                    out_ready
);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] data_q;
  logic [SEL_W-1:0] sel_q;
  logic             grant_valid;
  logic [SEL_W-1:0] grant_idx;
  logic             load_ok;
  logic             xfer;
  logic [WIDTH-1:0] sel_data;

  rr_grant #(
    .NUM_CH (NUM_CH)
  ) u_grant (
    .in_valid    (in_valid),
    .rr_ptr      (rr_ptr_q),
    .mode        (mode),
    .fix_sel     (fix_sel),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // rst_n gates the handshake so no producer sees ready while reset is held.
  assign load_ok = rst_n && ((state_q == EMPTY) || out_ready);
  assign xfer    = load_ok && grant_valid;

  always_comb begin
    in_ready = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      in_ready[k] = xfer && (grant_idx == SEL_W'(k));
    end
  end

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (grant_idx == SEL_W'(k)) sel_data = in_data[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      EMPTY:  if (xfer) state_d = LOADED;
      LOADED: begin
        if (xfer) state_d = LOADED;
        else if (out_ready) state_d = EMPTY;
      end
    endcase
    if (xfer && (mode == MODE_RR)) begin
      rr_ptr_d = (grant_idx == SEL_W'(NUM_CH - 1)) ? '0 : grant_idx + SEL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      sel_q  <= '0;
    end else if (xfer) begin
      data_q <= sel_data;
      sel_q  <= grant_idx;
    end
  end

`ifdef RRMUX_PARITY_EN
  logic par_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else if (xfer) begin
      par_q <= ^sel_data;
    end
  end

  assign out_par = par_q;
`endif

  assign out_data  = data_q;
  assign out_sel   = sel_q;
  assign out_valid = (state_q == LOADED);

endmodule
